data_sram_resp: RTL and testbench
=================================

Name: data_sram_resp

Overview:
- Responder end of the data-SRAM request interface driven by the execute stage (`data_sram_en` / `data_sram_wen` / `data_sram_addr` / `data_sram_wdata`).
- Holds a word-organised, byte-lane-writable data memory and returns registered read data to the memory stage.
- Can model a slow memory by inserting wait states; it raises a stall request so the pipeline holds the request in place.

Parameters:
- AW, 10, word-address width; depth is 2**AW words.
- BASE_ADDR, 32'h0000_0000, base of the decoded region; must be aligned to 2**(AW+2).
- WAIT_CYCLES, 0, stall cycles inserted per access (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_sram_en  in  1  request valid.
- data_sram_wen  in  4  byte-lane write enables; 4'b0000 with en=1 means a read.
- data_sram_addr  in  32  byte address.
- data_sram_wdata  in  32  write data, already lane-replicated by the requester.
- data_sram_rdata  out  32  registered read word (all 4 lanes); the requester extracts bytes/halfwords.
- stallreq_for_mem  out  1  `Stop while a wait-stated access is pending.
- addr_err  out  1  one-cycle pulse: the previous accepted access fell outside the region.

Behaviour:
- Reset (async, any state): data_sram_rdata=0, stallreq_for_mem=`NoStop (0), addr_err=0, FSM=IDLE, counter=0. Memory array contents are NOT cleared. A pending write is dropped, never committed.
- Decode:
  - hit = (addr[31:AW+2] == BASE_ADDR[31:AW+2]).
  - Word index = addr[AW+1:2]; addr[1:0] is ignored for indexing (lanes come from wen).
- Write (en=1, wen!=0, hit): each lane i with wen[i]=1 updates byte i at the commit edge; other lanes are unchanged. data_sram_rdata holds its previous value.
- Read (en=1, wen=0, hit): data_sram_rdata = mem[index], valid from the edge after the commit cycle and held until the next accepted read.
- Miss: no write; a read loads rdata=0; addr_err=1 for exactly the cycle after commit.
- en=0: wen, addr and wdata are ignored; no state change except addr_err returning to 0.
- Read-after-write, same word, back-to-back: the read returns the newly written bytes (array write precedes the next-cycle read; no bypass needed).
- WAIT_CYCLES=0:
  - No FSM activity; stallreq_for_mem stays 0.
  - The commit cycle is the request cycle; read latency is 1 cycle.
- WAIT_CYCLES=W>0, FSM states IDLE, BUSY, DONE:
  - IDLE & en=1: stallreq=1 combinationally in this same cycle. Latch addr/wen/wdata. cnt<=W-1. Next state is BUSY if W>1, else DONE.
  - BUSY: stallreq=1; cnt decrements; at cnt==1 the next state is DONE.
  - DONE: stallreq=0. The latched request commits at this edge (write lanes or rdata load). Next state is IDLE.
  - Net effect: stallreq is high for exactly W cycles per access, followed by one commit cycle; read data appears the cycle after DONE.
  - Inputs are ignored in BUSY/DONE; the latched copy is authoritative.
  - Back-to-back requests: IDLE accepts the new request in the cycle after DONE, with no idle bubble from the responder.
- rst asserted mid-BUSY: return to IDLE, stall drops asynchronously, no commit.

Decomposition:
- Shared defines header (defines.vh): `Stop/`NoStop (already present), plus new constants DataSramAW default and the IDLE/BUSY/DONE 2-bit state encodings.
- One sub-module: data_sram_array, a single-port synchronous RAM with 4 byte-lane write enables and a registered read port. The read register is held when no read is committed.
- Decode, FSM, wait counter and addr_err live in data_sram_resp.

Test Plan:
- W=0: write addr 0x10, wen=4'b1111, wdata 0x12345678; next cycle read 0x10 -> rdata=0x12345678 one cycle later, stall stays 0.
- W=0, byte lanes: word 0x20 preloaded 0xAABBCCDD; sb-style wen=4'b0100, wdata 0x11111111; read 0x22 -> rdata=0xAA11CCDD. Then sh-style wen=4'b0011, wdata 0x55665566 -> rdata=0xAA115566.
- W=3: read 0x40 (content 0xCAFEF00D) -> stallreq high exactly 3 cycles starting in the request cycle, then 0 for one cycle; rdata=0xCAFEF00D on the following edge. Toggling wdata/addr inputs during the stall has no effect.
- Miss: BASE_ADDR=0, AW=10, read 0x0000_1000 -> rdata=0, addr_err=1 for one cycle. A write to 0x0000_1000 leaves word 0 unchanged.
- Reset mid-op: W=4 write 0x8 wdata 0xFFFFFFFF, assert rst in second BUSY cycle -> stall=0 immediately, state IDLE; later read 0x8 returns its prior content.
- Back-to-back W=2: write 0x4 then read 0x4 -> two stall windows of 2 cycles each, separated by one commit cycle; read returns the written data.

Source files
------------

// File: rtl/data_sram_resp_pkg.sv
// rtl/data_sram_resp_pkg.sv - shared constants and decode helper for the data-SRAM responder
//
// Contents:
//   STOP / NO_STOP        stall request levels seen by the pipeline
//   DATA_SRAM_AW          default word-address width
//   ST_IDLE/BUSY/DONE     2-bit wait-state FSM encodings
//   region_hit()          region decode on the bits above the word index
package data_sram_resp_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int DATA_SRAM_AW = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Compares only the bits above the word index and byte offset, so the
  // region is 2**(aw+2) bytes starting at base.
  function automatic logic region_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int          aw);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << (aw + 2);
    return ((addr ^ base) & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/data_sram_array.sv
// rtl/data_sram_array.sv - single-port word RAM with byte-lane writes and registered read
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   async active-high reset (clears the read register only)
//   we     in   4 byte-lane write enables
//   re     in   load read register from mem[addr]
//   clr    in   load read register with zero (miss read)
//   addr   in   AW-bit word index
//   wdata  in   32-bit write data, lane-replicated
//   rdata  out  32-bit registered read word, held when no read commits
module data_sram_array
  import data_sram_resp_pkg::*;
#(
  parameter int AW = DATA_SRAM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic          clr,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // Array contents survive reset; only the port register is cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= 32'd0;
    end else if (clr) begin
      rdata <= 32'd0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - data-SRAM responder with optional wait states and region decode
//
// Ports:
//   clk               in   rising-edge clock
//   rst               in   async active-high reset
//   data_sram_en      in   request valid
//   data_sram_wen     in   byte-lane write enables, 0 means read
//   data_sram_addr    in   byte address
//   data_sram_wdata   in   lane-replicated write data
//   data_sram_rdata   out  registered read word
//   stallreq_for_mem  out  STOP while a wait-stated access is pending
//   addr_err          out  one-cycle pulse after a committed access missed the region
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          AW          = DATA_SRAM_AW,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_for_mem,
  output logic        addr_err
);

  // The request that acts on the array this cycle: live inputs without wait
  // states, the latched copy in DONE otherwise.
  logic        cmt_valid;
  logic [3:0]  cmt_wen;
  logic [31:0] cmt_addr;
  logic [31:0] cmt_wdata;

  generate
    if (WAIT_CYCLES == 0) begin : g_nowait
      // Gating with rst drops a write that coincides with a reset edge.
      assign cmt_valid        = data_sram_en & ~rst;
      assign cmt_wen          = data_sram_wen;
      assign cmt_addr         = data_sram_addr;
      assign cmt_wdata        = data_sram_wdata;
      assign stallreq_for_mem = NO_STOP;
    end else begin : g_wait
      logic [1:0]  state;
      logic [3:0]  cnt;
      logic [3:0]  lat_wen;
      logic [31:0] lat_addr;
      logic [31:0] lat_wdata;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state     <= ST_IDLE;
          cnt       <= 4'd0;
          lat_wen   <= 4'd0;
          lat_addr  <= 32'd0;
          lat_wdata <= 32'd0;
        end else begin
          case (state)
            ST_IDLE: begin
              if (data_sram_en) begin
                lat_wen   <= data_sram_wen;
                lat_addr  <= data_sram_addr;
                lat_wdata <= data_sram_wdata;
                cnt       <= 4'(WAIT_CYCLES - 1);
                state     <= (WAIT_CYCLES > 1) ? ST_BUSY : ST_DONE;
              end
            end
            ST_BUSY: begin
              cnt <= cnt - 4'd1;
              if (cnt == 4'd1) begin
                state <= ST_DONE;
              end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
          endcase
        end
      end

      // The IDLE term is combinational so the pipeline freezes in the very
      // cycle the request appears; IDLE plus BUSY cycles add up to WAIT_CYCLES.
      assign stallreq_for_mem = (~rst && ((state == ST_IDLE && data_sram_en) ||
                                          state == ST_BUSY)) ? STOP : NO_STOP;
      assign cmt_valid = (state == ST_DONE);
      assign cmt_wen   = lat_wen;
      assign cmt_addr  = lat_addr;
      assign cmt_wdata = lat_wdata;
    end
  endgenerate

  logic       hit;
  logic       is_read;
  logic [3:0] arr_we;
  logic       arr_re;
  logic       arr_clr;

  assign hit     = region_hit(cmt_addr, BASE_ADDR, AW);
  assign is_read = (cmt_wen == 4'd0);
  assign arr_we  = (cmt_valid && hit) ? cmt_wen : 4'd0;
  assign arr_re  = cmt_valid && hit && is_read;
  assign arr_clr = cmt_valid && !hit && is_read;

  data_sram_array #(
    .AW(AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .re    (arr_re),
    .clr   (arr_clr),
    .addr  (cmt_addr[AW+1:2]),
    .wdata (cmt_wdata),
    .rdata (data_sram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else begin
      addr_err <= cmt_valid && !hit;
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// tb/tb_data_sram_resp.sv - self-checking bench for data_sram_resp at WAIT_CYCLES 0, 3, 2 and 4
module tb_data_sram_resp;

  function automatic int wait_of(input int g);
    return (g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 2 : 4;
  endfunction

  logic        clk = 1'b0;
  logic        rst   [4];
  logic        en    [4];
  logic [3:0]  wen   [4];
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  logic [31:0] rdata [4];
  logic        stall [4];
  logic        err   [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    data_sram_resp #(
      .AW          (10),
      .BASE_ADDR   (32'h0000_0000),
      .WAIT_CYCLES (wait_of(g))
    ) u_dut (
      .clk              (clk),
      .rst              (rst[g]),
      .data_sram_en     (en[g]),
      .data_sram_wen    (wen[g]),
      .data_sram_addr   (addr[g]),
      .data_sram_wdata  (wdata[g]),
      .data_sram_rdata  (rdata[g]),
      .stallreq_for_mem (stall[g]),
      .addr_err         (err[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Starts at a negedge; returns one negedge (+1) after the commit edge with
  // en dropped. nst counts cycles in which the stall request was seen high.
  task automatic do_access(input int k, input logic [3:0] w, input logic [31:0] a,
                           input logic [31:0] d, input logic scr, output int nst);
    en[k] = 1'b1; wen[k] = w; addr[k] = a; wdata[k] = d;
    nst = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stall[k]) break;
      nst++;
      @(posedge clk); @(negedge clk);
      if (scr) begin
        addr[k] = $urandom; wdata[k] = $urandom; wen[k] = 4'($urandom);
      end
    end
    if (nst >= 40) chk("stall_timeout", 32'(nst), 32'd0);
    @(posedge clk); @(negedge clk); #1;
    en[k] = 1'b0; wen[k] = 4'd0;
  endtask

  typedef struct {
    int          k;
    logic [3:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    logic        scr;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_st;
  } vec_t;

  vec_t tab[$];
  logic [31:0] mm [2][16];
  logic [31:0] lr [2];

  initial begin
    int nst, nst2;
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1; en[k] = 1'b0; wen[k] = 4'd0; addr[k] = 32'd0; wdata[k] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_rdata%0d", k), rdata[k], 32'd0);
      chk($sformatf("rst_stall%0d", k), 32'(stall[k]), 32'd0);
      chk($sformatf("rst_err%0d", k), 32'(err[k]), 32'd0);
      rst[k] = 1'b0;
    end
    @(negedge clk);

    //               k  wen     addr          wdata        scr  chk  exp_rd        err st
    tab.push_back('{0, 4'hF, 32'h0000_0010, 32'h1234_5678, 0, 0, 32'h0,          0, 0});
    tab.push_back('{0, 4'h0, 32'h0000_0010, 32'h0,         0, 1, 32'h1234_5678,  0, 0});
    tab.push_back('{0, 4'hF, 32'h0000_0020, 32'hAABB_CCDD, 0, 1, 32'h1234_5678,  0, 0});
    tab.push_back('{0, 4'h4, 32'h0000_0022, 32'h1111_1111, 0, 0, 32'h0,          0, 0});
    tab.push_back('{0, 4'h0, 32'h0000_0022, 32'h0,         0, 1, 32'hAA11_CCDD,  0, 0});
    tab.push_back('{0, 4'h3, 32'h0000_0020, 32'h5566_5566, 0, 1, 32'hAA11_CCDD,  0, 0});
    tab.push_back('{0, 4'h0, 32'h0000_0020, 32'h0,         0, 1, 32'hAA11_5566,  0, 0});
    tab.push_back('{0, 4'hF, 32'h0000_0000, 32'h0BAD_BEEF, 0, 0, 32'h0,          0, 0});
    tab.push_back('{0, 4'h0, 32'h0000_1000, 32'h0,         0, 1, 32'h0,          1, 0});
    tab.push_back('{0, 4'hF, 32'h0000_1000, 32'hDEAD_DEAD, 0, 1, 32'h0,          1, 0});
    tab.push_back('{0, 4'h0, 32'h0000_0000, 32'h0,         0, 1, 32'h0BAD_BEEF,  0, 0});
    tab.push_back('{1, 4'hF, 32'h0000_0040, 32'hCAFE_F00D, 0, 0, 32'h0,          0, 3});
    tab.push_back('{1, 4'h0, 32'h0000_0040, 32'h0,         1, 1, 32'hCAFE_F00D,  0, 3});
    tab.push_back('{3, 4'hF, 32'h0000_0008, 32'h0102_0304, 0, 0, 32'h0,          0, 4});
    tab.push_back('{3, 4'h0, 32'h0000_0008, 32'h0,         0, 1, 32'h0102_0304,  0, 4});

    foreach (tab[i]) begin
      do_access(tab[i].k, tab[i].w, tab[i].a, tab[i].d, tab[i].scr, nst);
      chk($sformatf("vec%0d_stall", i), 32'(nst), 32'(tab[i].exp_st));
      chk($sformatf("vec%0d_err", i), 32'(err[tab[i].k]), 32'(tab[i].exp_err));
      if (tab[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rdata[tab[i].k], tab[i].exp_rd);
    end
    @(negedge clk);
    chk("err_drops", 32'(err[0]), 32'd0);

    // Back-to-back W=2: write then read with no idle cycle in between.
    do_access(2, 4'hF, 32'h0000_0004, 32'h1357_9BDF, 1'b0, nst);
    do_access(2, 4'h0, 32'h0000_0004, 32'h0, 1'b0, nst2);
    chk("b2b_stall_wr", 32'(nst), 32'd2);
    chk("b2b_stall_rd", 32'(nst2), 32'd2);
    chk("b2b_rdata", rdata[2], 32'h1357_9BDF);

    // Reset in the second BUSY cycle of a W=4 write.
    @(negedge clk);
    en[3] = 1'b1; wen[3] = 4'hF; addr[3] = 32'h0000_0008; wdata[3] = 32'hFFFF_FFFF;
    #1 chk("mid_stall_on", 32'(stall[3]), 32'd1);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #1 rst[3] = 1'b1; en[3] = 1'b0; wen[3] = 4'd0;
    #1 chk("mid_stall_off", 32'(stall[3]), 32'd0);
    chk("mid_rdata_rst", rdata[3], 32'd0);
    @(negedge clk); rst[3] = 1'b0;
    repeat (3) @(negedge clk);
    do_access(3, 4'h0, 32'h0000_0008, 32'h0, 1'b0, nst);
    chk("mid_idle_stall", 32'(nst), 32'd4);
    chk("mid_prior", rdata[3], 32'h0102_0304);

    // Randomized accesses on W=0 and W=3 against a word-array model.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        mm[k][i] = $urandom;
        do_access(k, 4'hF, 32'(i * 4), mm[k][i], 1'b0, nst);
      end
      do_access(k, 4'h0, 32'h0, 32'h0, 1'b0, nst);
      lr[k] = mm[k][0];
      chk($sformatf("rnd%0d_init", k), rdata[k], lr[k]);
    end
    for (int n = 0; n < 300; n++) begin
      int          k;
      logic [3:0]  w;
      logic [31:0] a, d;
      logic        hit;
      logic [3:0]  idx;
      int          gap;
      k = n % 2;
      d = $urandom;
      w = ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom);
      if ($urandom_range(0, 9) == 0) a = {20'($urandom_range(1, 20'hFFFFF)), 12'($urandom)};
      else a = {26'd0, 4'($urandom), 2'($urandom)};
      hit = (a[31:12] == 20'd0);
      idx = a[5:2];
      if (w == 4'd0) lr[k] = hit ? mm[k][idx] : 32'd0;
      else if (hit)
        for (int b = 0; b < 4; b++) if (w[b]) mm[k][idx][8*b +: 8] = d[8*b +: 8];
      do_access(k, w, a, d, k == 1, nst);
      chk($sformatf("rnd%0d_stall", n), 32'(nst), 32'(wait_of(k)));
      chk($sformatf("rnd%0d_err", n), 32'(err[k]), 32'(!hit));
      chk($sformatf("rnd%0d_rdata", n), rdata[k], lr[k]);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); #1;
        chk($sformatf("rnd%0d_idle_err", n), 32'(err[k]), 32'd0);
        chk($sformatf("rnd%0d_idle_rd", n), rdata[k], lr[k]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
